ram_upload_reader: RTL
======================

RAM_UPLOAD_READER -- requirements
Module: ram_upload_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the game RAM address width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the region-length field (max 256 bytes).
REQ-003 SHALL have parameter UPLOAD_INDEX, default 4, meaning the ioctl_index value this block serves.
REQ-004 SHALL have parameter RAM_LAT, default 1, meaning the game-RAM read latency in clk_sys cycles.
REQ-005 SHALL have port clk_sys, input, width 1, the single clock.
REQ-006 SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-007 SHALL have ports ioctl_upload (in, 1), ioctl_index (in, 8) and ioctl_addr (in, 25), the host upload session, index and byte address.
REQ-008 SHALL have port ioctl_din, output, width 8, the byte returned to the host.
REQ-009 SHALL have ports cfg_base (in, ADDR_W) and cfg_len (in, LEN_W+1), the start address of the saved RAM region and its length in bytes.
REQ-010 SHALL have port save_req, input, width 1, a one-cycle pulse requesting an autosave.
REQ-011 SHALL have port upload_req, output, width 1, a request to the host to start an upload.
REQ-012 SHALL have ports cpu_paused (in, 1), ram_addr (out, ADDR_W), ram_data (in, 8) and ram_access (out, 1) for RAM arbitration.
REQ-013 SHALL have port pause_cpu, output, width 1, the request to freeze the game CPU.
REQ-014 SHALL have port busy, output, width 1, high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, HALT, FETCH, WAIT, HOLD.
REQ-016 SHALL leave IDLE for HALT, asserting pause_cpu, on a rising edge of ioctl_upload while ioctl_index==UPLOAD_INDEX; other indices SHALL be ignored.
REQ-017 SHALL move from HALT to FETCH on the first cycle in which cpu_paused=1, and SHALL hold ram_access low until then.
REQ-018 SHALL, in FETCH, drive ram_addr=cfg_base+ioctl_addr[ADDR_W-1:0] (modulo 2^ADDR_W, wrap permitted), assert ram_access, and go to WAIT.
REQ-019 SHALL wait RAM_LAT cycles in WAIT, then register ram_data into ioctl_din and go to HOLD.
REQ-020 SHALL set ioctl_din=8'hFF without reading RAM when ioctl_addr>=cfg_len.
REQ-021 SHALL guarantee that ioctl_din is valid no later than RAM_LAT+3 cycles after ioctl_addr changes.
REQ-022 SHALL, in HOLD, keep ioctl_din stable, latch ioctl_addr, and return to FETCH whenever ioctl_addr differs from the latched value.
REQ-023 SHALL perform a single fetch when ioctl_addr changes twice before the fetch completes, using the newest address.
REQ-024 SHALL, when ioctl_upload falls in any state, go to IDLE the next cycle and deassert pause_cpu and ram_access.
REQ-025 SHALL set upload_req on save_req while in IDLE and clear it on the rising edge of ioctl_upload; a save_req while busy SHALL be ignored.
REQ-026 SHALL give the upload edge priority when save_req and the ioctl_upload rising edge occur in the same cycle; upload_req SHALL remain 0.
REQ-027 SHALL return 8'hFF for every address when cfg_len=0, without issuing any RAM access.
REQ-028 SHALL sample cfg_base and cfg_len on session start and hold them constant for the rest of the session.

Reset
REQ-029 SHALL, on reset, set the state to IDLE and set pause_cpu=0, ram_access=0, upload_req=0, busy=0, ioctl_din=8'h00, ram_addr=0.
REQ-030 SHALL, when reset is asserted mid-session, release pause_cpu the following cycle and SHALL NOT treat an ioctl_upload that is still high as a new edge.

Structure
REQ-031 SHALL place the FSM state enum and the UPLOAD_INDEX default in a shared package, hs_pkg.
REQ-032 SHALL be a single module with no sub-modules; the RAM-latency delay SHALL be an inline counter.

Verification
REQ-033 SHALL verify: cfg_base=16'h6100, cfg_len=4, RAM[6100..6103]=11,22,33,44, upload at index 4 with addresses 0..3 -> ioctl_din=11,22,33,44, each valid by RAM_LAT+3 cycles.
REQ-034 SHALL verify: cpu_paused held 0 for 20 cycles after the upload edge -> ram_access=0 and pause_cpu=1 throughout; first fetch occurs after cpu_paused rises.
REQ-035 SHALL verify: ioctl_addr=5 with cfg_len=4 -> ioctl_din=FF and no ram_access pulse.
REQ-036 SHALL verify: save_req pulse in IDLE -> upload_req=1 until the upload edge, then 0; save_req while busy -> upload_req stays 0.
REQ-037 SHALL verify: reset asserted during WAIT with ioctl_upload held 1 -> IDLE and pause_cpu=0 the next cycle, and no restart until ioctl_upload toggles.
REQ-038 SHALL verify: cfg_base=16'hFFFE, cfg_len=4 -> RAM reads at FFFE, FFFF, 0000, 0001.

Source files
------------

// File: rtl/hs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : hs_pkg                                                   |
// | Shared FSM state encoding and default host-upload index for the    |
// | RAM upload reader.                                                 |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package hs_pkg;

    // Default ioctl_index value that selects the RAM-save upload
    localparam int UPLOAD_INDEX_DEFAULT = 4;

    // Reader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/ram_upload_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : ram_upload_reader_if                                   |
// | Host ioctl upload bus: session flag, index, byte address and the   |
// | byte returned to the host.                                         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface ram_upload_reader_if;

    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    // Host side: drives the session, reads back data
    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_addr,
        input  ioctl_din
    );

    // Reader side: follows the session, supplies data
    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_addr,
        output ioctl_din
    );

endinterface : ram_upload_reader_if
`default_nettype wire

// File: rtl/ram_upload_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ram_upload_reader                                         |
// | Serves a host upload of a saved game-RAM region: freezes the CPU,  |
// | reads bytes at cfg_base+ioctl_addr and returns them on ioctl_din,  |
// | padding with FF beyond cfg_len. Also raises upload_req on autosave.|
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module ram_upload_reader
    import hs_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int LEN_W        = 8,
    parameter int UPLOAD_INDEX = UPLOAD_INDEX_DEFAULT,
    parameter int RAM_LAT      = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    ram_upload_reader_if.slave  io,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LEN_W:0]      cfg_len,
    input  logic                save_req,
    output logic                upload_req,
    input  logic                cpu_paused,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [7:0]          ram_data,
    output logic                ram_access,
    output logic                pause_cpu,
    output logic                busy
);

    localparam int CNT_W = (RAM_LAT < 1) ? 1 : $clog2(RAM_LAT + 1);

    state_t              state_q, state_d;
    logic                upl_prev_q;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W:0]      len_q, len_d;
    logic [24:0]         addr_q, addr_d;
    logic [7:0]          din_q, din_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                upload_req_q, upload_req_d;
    logic                upl_rise;
    logic                addr_changed;

    assign upl_rise     = io.ioctl_upload && !upl_prev_q;
    assign addr_changed = (io.ioctl_addr != addr_q);

    assign io.ioctl_din = din_q;
    assign ram_addr     = ram_addr_q;
    assign upload_req   = upload_req_q;
    // The RAM read is in flight only while waiting out its latency
    assign ram_access   = (state_q == ST_WAIT);
    assign pause_cpu    = (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE);

    // Next-state and datapath decode for the upload session
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        addr_d       = addr_q;
        din_d        = din_q;
        ram_addr_d   = ram_addr_q;
        cnt_d        = cnt_q;
        upload_req_d = upload_req_q;

        // A session start wins over an autosave arriving in the same cycle
        if (upl_rise) begin
            upload_req_d = 1'b0;
        end else if (save_req && (state_q == ST_IDLE)) begin
            upload_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (upl_rise && (io.ioctl_index == 8'(UPLOAD_INDEX))) begin
                    state_d = ST_HALT;
                    base_d  = cfg_base;
                    len_d   = cfg_len;
                end
            end
            ST_HALT: begin
                if (cpu_paused) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Always fetch the newest address; beyond the region pad with FF
                addr_d = io.ioctl_addr;
                if (io.ioctl_addr >= 25'(len_q)) begin
                    din_d   = 8'hFF;
                    state_d = ST_HOLD;
                end else begin
                    ram_addr_d = base_q + io.ioctl_addr[ADDR_W-1:0];
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A newer address abandons this read so only one result lands
                if (addr_changed) begin
                    state_d = ST_FETCH;
                end else if (cnt_q == CNT_W'(RAM_LAT)) begin
                    din_d   = ram_data;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (addr_changed) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of session returns to idle from anywhere
        if ((state_q != ST_IDLE) && !io.ioctl_upload) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers; upload history resets high so a
    // session still open across reset is not seen as a new start
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            upl_prev_q   <= 1'b1;
            base_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            din_q        <= 8'h00;
            ram_addr_q   <= '0;
            cnt_q        <= '0;
            upload_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            upl_prev_q   <= io.ioctl_upload;
            base_q       <= base_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            ram_addr_q   <= ram_addr_d;
            cnt_q        <= cnt_d;
            upload_req_q <= upload_req_d;
        end
    end

endmodule : ram_upload_reader
`default_nettype wire
